// File: rtl/mini16sc_dmem_resp.sv
// Data memory with a single-cycle core load/store path and a host request port
// that shares the storage. The host request port is handled by a small FSM.
// The core store always wins the write port. A host write waits in WPEND until
// a cycle with no core store, and every waiting cycle is counted in
// stall_count, which saturates at 255.
// Optional build macro: MINI16SC_DMEM_WFWD_EN
//   defined   - a core load that hits the address being stored in the same
//               cycle returns the new data (write-first).
//   undefined - the same collision returns the old stored word (read-first).
//
// state | meaning
// IDLE  | host_ready high (once out of reset); accept a host read or write
// WPEND | host write latched; lands on the first cycle without a core store
// RD    | host read address latched; read it on the second read port
// RESP  | host_rvalid pulse; host_rdata holds the read word
module mini16sc_dmem_resp #(
  parameter int WIDTH_D = 16,
  parameter int DEPTH_D = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH_D-1:0] mem_d_r_addr,
  output logic [WIDTH_D-1:0] mem_d_r_data,
  input  logic [DEPTH_D-1:0] mem_d_w_addr,
  input  logic [WIDTH_D-1:0] mem_d_w_data,
  input  logic               mem_d_we,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               host_we,
  input  logic [DEPTH_D-1:0] host_addr,
  input  logic [WIDTH_D-1:0] host_wdata,
  output logic               host_rvalid,
  output logic [WIDTH_D-1:0] host_rdata,
  output logic [7:0]         stall_count
);

  localparam int WORDS = 1 << DEPTH_D;

  typedef enum logic [1:0] {IDLE, WPEND, RD, RESP} state_t;

  state_t             state, state_nxt;
  logic               ready_en;
  logic [DEPTH_D-1:0] h_addr;
  logic [WIDTH_D-1:0] h_wdata;
  logic               accept;
  logic               host_wr_go;
  logic               core_fwd;
  logic               rd_fwd;
  logic [WIDTH_D-1:0] mem [WORDS];

  assign accept = host_valid && host_ready;

  // A core store that lands on the same edge as the host read is still returned.
  assign rd_fwd = mem_d_we && (mem_d_w_addr == h_addr);

`ifdef MINI16SC_DMEM_WFWD_EN
  assign core_fwd = mem_d_we && (mem_d_w_addr == mem_d_r_addr);
`else
  assign core_fwd = 1'b0;
`endif

  // Host FSM next-state and outputs; ready is held low until the first edge after reset.
  always_comb begin
    state_nxt   = state;
    host_ready  = 1'b0;
    host_rvalid = 1'b0;
    host_wr_go  = 1'b0;
    case (state)
      IDLE: begin
        host_ready = ready_en;
        if (host_valid && ready_en) state_nxt = host_we ? WPEND : RD;
      end
      WPEND: begin
        if (!mem_d_we) begin
          host_wr_go = 1'b1;
          state_nxt  = IDLE;
        end
      end
      RD:      state_nxt = RESP;
      RESP: begin
        host_rvalid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Host FSM state, latched request, stall counter and host read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      h_addr      <= '0;
      h_wdata     <= '0;
      stall_count <= '0;
      host_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        h_addr  <= host_addr;
        h_wdata <= host_wdata;
      end
      if (state == WPEND && mem_d_we && stall_count != 8'hFF)
        stall_count <= stall_count + 8'd1;
      if (state == RD)
        host_rdata <= rd_fwd ? mem_d_w_data : mem[h_addr];
    end
  end

  // Storage write port: the core store has priority; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_d_we)
      mem[mem_d_w_addr] <= mem_d_w_data;
    else if (host_wr_go)
      mem[h_addr] <= h_wdata;
  end

  // Core load port with one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mem_d_r_data <= '0;
    else if (core_fwd)
      mem_d_r_data <= mem_d_w_data;
    else
      mem_d_r_data <= mem[mem_d_r_addr];
  end

endmodule

// File: doc/mini16sc_dmem_resp.md
MINI16SC_DMEM_RESP -- requirements
Module: mini16sc_dmem_resp

Interface
REQ-001 SHALL have parameter WIDTH_D, default 16, data word width.
REQ-002 SHALL have parameter DEPTH_D, default 8, address width; storage holds 2^DEPTH_D words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port mem_d_r_addr  input  DEPTH_D  core load address.
REQ-006 SHALL have port mem_d_r_data  output  WIDTH_D  core load data, registered.
REQ-007 SHALL have port mem_d_w_addr  input  DEPTH_D  core store address.
REQ-008 SHALL have port mem_d_w_data  input  WIDTH_D  core store data.
REQ-009 SHALL have port mem_d_we  input  1  core store strobe, one cycle per store.
REQ-010 SHALL have port host_valid  input  1  host request valid.
REQ-011 SHALL have port host_ready  output  1  host request accepted when valid and ready are both high.
REQ-012 SHALL have port host_we  input  1  host request is write (1) or read (0).
REQ-013 SHALL have port host_addr  input  DEPTH_D  host address.
REQ-014 SHALL have port host_wdata  input  WIDTH_D  host write data.
REQ-015 SHALL have port host_rvalid  output  1  one-cycle pulse, host read data valid.
REQ-016 SHALL have port host_rdata  output  WIDTH_D  host read data, held until next host read.
REQ-017 SHALL have port stall_count  output  8  saturating count of cycles a host write waited on a core store.

Function
REQ-018 SHALL update mem_d_r_data every cycle to the word at the mem_d_r_addr sampled on the previous edge (1-cycle read latency).
REQ-019 SHALL write mem_d_w_data to mem_d_w_addr on the edge where mem_d_we=1; the core store is never stalled or dropped.
REQ-020 SHALL run a host FSM with states IDLE, WPEND, RD, RESP.
REQ-021 IDLE: host_ready=1; accepted write goes to WPEND with addr/data latched; accepted read goes to RD with addr latched.
REQ-022 WPEND: host_ready=0; write the latched data when mem_d_we=0 that cycle, then go to IDLE; otherwise stay and increment stall_count (saturate at 255).
REQ-023 RD: host_ready=0; read the latched address on the second read port, go to RESP.
REQ-024 RESP: host_rvalid=1 for exactly one cycle, host_rdata valid; go to IDLE; host_ready=0.
REQ-025 Host write latency is 1 cycle from acceptance when uncontended; host read returns data 2 cycles after acceptance.
REQ-026 A host read SHALL return data including any core store that completed on or before the RD cycle edge.
REQ-027 If the core and WPEND target the same address, the core store SHALL be written first and the host write SHALL overwrite it on a later edge.
REQ-028 host_valid with host_ready=0 SHALL have no effect; request fields are sampled only at acceptance.

Reset
REQ-029 While reset=0: FSM=IDLE, host_ready=0, host_rvalid=0, host_rdata=0, mem_d_r_data=0, stall_count=0, pending write discarded.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 host_ready SHALL rise on the first edge after reset deasserts; reset mid-transaction aborts it with no write and no rvalid.

Configuration
REQ-032 Macro MINI16SC_DMEM_WFWD_EN defined: when mem_d_we=1 and mem_d_w_addr equals mem_d_r_addr in the same cycle, next mem_d_r_data SHALL equal mem_d_w_data (write-first).
REQ-033 Macro MINI16SC_DMEM_WFWD_EN undefined: same collision returns the old stored word (read-first).

Verification
REQ-034 Core store 0x1234 to addr 5, then core read addr 5 -> mem_d_r_data=0x1234 one cycle after the address is presented.
REQ-035 Host write 0xBEEF to addr 9 while mem_d_we=0 -> host read addr 9 gives host_rvalid pulse with host_rdata=0xBEEF 2 cycles after acceptance.
REQ-036 Host write accepted, mem_d_we held 1 for 3 cycles -> WPEND held 3 cycles, stall_count=3, write lands on 4th cycle.
REQ-037 Same-cycle core write 0xAAAA and read addr 3 -> mem_d_r_data=0xAAAA with MINI16SC_DMEM_WFWD_EN, old value without.
REQ-038 Assert reset=0 during WPEND -> host_rvalid=0, stall_count=0, target word unchanged, host_ready=1 one edge after release.
REQ-039 Hold mem_d_we=1 for 300 cycles with host write pending -> stall_count saturates at 255.
